// File: rtl/script_sequencer.sv
// Script sequencer for the kitchen script engine: fetches 16-bit words from a
// synchronous ROM and runs action, jump, timed wait and wait-until instructions.
module script_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int TICKS_PER_UNIT = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              ms_tick,
    input  logic [7:0]        feedback_sig,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              act_valid,
    input  logic              act_ready,
    output logic [1:0]        act_type,
    output logic [7:0]        act_data,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state,
    output logic [15:0]       dbg_wait_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ACT    = 3'd3;
    localparam logic [2:0] S_WAIT_T = 3'd4;
    localparam logic [2:0] S_WAIT_S = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]        state;
    logic [2:0]        ir_sign;
    logic [15:0]       wait_cnt;
    logic [15:0]       wait_target;

    logic [7:0]        d_num;
    logic [2:0]        d_sign;
    logic [1:0]        d_func;
    logic [2:0]        d_op;
    logic              sel_dec;
    logic              sel_ir;
    logic              jump_taken;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jump_pc;
    logic              unused_fb;

    function automatic logic sel_of(input logic [2:0] s, input logic [7:0] fb);
        case (s)
            3'd0:    sel_of = fb[2];
            3'd1:    sel_of = fb[3];
            3'd2:    sel_of = fb[4];
            3'd3:    sel_of = fb[5];
            default: sel_of = 1'b0;
        endcase
    endfunction

    assign d_num   = rom_data[15:8];
    assign d_sign  = rom_data[7:5];
    assign d_func  = rom_data[4:3];
    assign d_op    = rom_data[2:0];
    assign sel_dec = sel_of(d_sign, feedback_sig);
    assign sel_ir  = sel_of(ir_sign, feedback_sig);
    assign pc_inc  = pc + ADDR_W'(1);
    assign jump_pc = ADDR_W'(d_num);
    assign unused_fb = ^{feedback_sig[7:6], feedback_sig[1:0]};

    always_comb begin
        jump_taken = 1'b0;
        case (d_func)
            2'b00:   jump_taken = 1'b1;
            2'b01:   jump_taken = sel_dec;
            2'b10:   jump_taken = ~sel_dec;
            default: jump_taken = 1'b0;
        endcase
    end

    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

    // Action handshake: act_valid rises on entry to ACT and act_type/act_data
    // hold until the cycle where act_valid && act_ready, after which it drops.
    // rom_addr always moves together with pc so the ROM word arrives in DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            rom_addr    <= '0;
            act_valid   <= 1'b0;
            act_type    <= 2'b00;
            act_data    <= 8'h00;
            done        <= 1'b0;
            wait_cnt    <= 16'd0;
            wait_target <= 16'd0;
            ir_sign     <= 3'd0;
        end else if (stop) begin
            state     <= S_IDLE;
            act_valid <= 1'b0;
            wait_cnt  <= 16'd0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc       <= '0;
                        rom_addr <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rom_addr <= pc;
                    state    <= S_DECODE;
                end
                S_DECODE: begin
                    ir_sign <= d_sign;
                    case (d_op)
                        3'b001: begin
                            act_type  <= d_func;
                            act_data  <= d_num;
                            act_valid <= 1'b1;
                            state     <= S_ACT;
                        end
                        3'b010: begin
                            pc       <= jump_taken ? jump_pc : pc_inc;
                            rom_addr <= jump_taken ? jump_pc : pc_inc;
                            state    <= S_FETCH;
                        end
                        3'b011: begin
                            if (d_func == 2'b00) begin
                                wait_target <= 16'(d_num) * 16'(TICKS_PER_UNIT);
                                wait_cnt    <= 16'd0;
                                state       <= S_WAIT_T;
                            end else if (d_func == 2'b01) begin
                                state <= S_WAIT_S;
                            end else begin
                                pc       <= pc_inc;
                                rom_addr <= pc_inc;
                                state    <= S_FETCH;
                            end
                        end
                        3'b111: begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                        default: begin
                            pc       <= pc_inc;
                            rom_addr <= pc_inc;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_ACT: begin
                    if (act_ready) begin
                        act_valid <= 1'b0;
                        pc        <= pc_inc;
                        rom_addr  <= pc_inc;
                        state     <= S_FETCH;
                    end
                end
                S_WAIT_T: begin
                    // Match is tested before counting, so a tick on the match cycle is dropped.
                    if (wait_cnt == wait_target) begin
                        pc       <= pc_inc;
                        rom_addr <= pc_inc;
                        state    <= S_FETCH;
                    end else if (ms_tick) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_WAIT_S: begin
                    if (sel_ir) begin
                        pc       <= pc_inc;
                        rom_addr <= pc_inc;
                        state    <= S_FETCH;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        done     <= 1'b0;
                        pc       <= '0;
                        rom_addr <= '0;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_script_sequencer.sv
// Directed bench for script_sequencer: an 8-bit-address instance for the main
// scenarios and a 2-bit-address instance for pc truncation and wrap.
module tb_script_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ACT    = 3'd3;
    localparam logic [2:0] S_WAIT_T = 3'd4;
    localparam logic [2:0] S_WAIT_S = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic        clk;
    logic        rst;
    logic        start, stop, ms_tick, act_ready;
    logic [7:0]  feedback_sig;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        act_valid;
    logic [1:0]  act_type;
    logic [7:0]  act_data;
    logic [7:0]  pc;
    logic        busy, done;
    logic [2:0]  dbg_state;
    logic [15:0] dbg_wait_cnt;

    logic        start_b, stop_b;
    logic [1:0]  rom_addr_b;
    logic [15:0] rom_data_b;
    logic        act_valid_b;
    logic [1:0]  act_type_b;
    logic [7:0]  act_data_b;
    logic [1:0]  pc_b;
    logic        busy_b, done_b;
    logic [2:0]  dbg_state_b;
    logic [15:0] dbg_wait_cnt_b;

    logic [15:0] rom   [256];
    logic [15:0] rom_b [4];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int xfers = 0;
    int wt_ticks = 0;
    int last_tick_cyc = 0;
    int div = 0;
    logic tick_en = 1'b0;

    script_sequencer #(.ADDR_W(8), .TICKS_PER_UNIT(100)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .ms_tick(ms_tick),
        .feedback_sig(feedback_sig), .rom_addr(rom_addr), .rom_data(rom_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_type(act_type),
        .act_data(act_data), .pc(pc), .busy(busy), .done(done),
        .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
    );

    script_sequencer #(.ADDR_W(2), .TICKS_PER_UNIT(100)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .ms_tick(1'b0),
        .feedback_sig(8'h00), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .act_valid(act_valid_b), .act_ready(1'b1), .act_type(act_type_b),
        .act_data(act_data_b), .pc(pc_b), .busy(busy_b), .done(done_b),
        .dbg_state(dbg_state_b), .dbg_wait_cnt(dbg_wait_cnt_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) begin
        rom_data   <= rom[rom_addr];
        rom_data_b <= rom_b[rom_addr_b];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (act_valid && act_ready) xfers <= xfers + 1;
        if (ms_tick && dbg_state == S_WAIT_T) begin
            wt_ticks      <= wt_ticks + 1;
            last_tick_cyc <= cyc;
        end
    end

    // ms_tick driver: one pulse every 5 cycles while enabled
    initial begin
        ms_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                ms_tick = (div == 4);
                div = (div == 4) ? 0 : div + 1;
            end else begin
                ms_tick = 1'b0;
                div = 0;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int x0;
    int t0;
    logic found;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; act_ready = 1'b1;
        feedback_sig = 8'h00; start_b = 1'b0; stop_b = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 4; i++) rom_b[i] = 16'h0000;
        step(); step();
        check("rst_pc", pc, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_act_valid", act_valid, 0);
        check("rst_act_type", act_type, 0);
        check("rst_act_data", act_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_wait_cnt", dbg_wait_cnt, 0);
        check("rst_pc_b", pc_b, 0);
        rst = 1'b0;
        step();

        // action with immediate ready
        rom[0] = 16'h5A11; rom[1] = 16'h0007;
        x0 = xfers;
        start = 1'b1; step(); start = 1'b0;
        check("t1_c1_state", dbg_state, S_FETCH);
        check("t1_c1_busy", busy, 1);
        check("t1_c1_valid", act_valid, 0);
        step();
        check("t1_c2_state", dbg_state, S_DECODE);
        check("t1_c2_valid", act_valid, 0);
        step();
        check("t1_c3_valid", act_valid, 1);
        check("t1_c3_type", act_type, 2);
        check("t1_c3_data", act_data, 8'h5A);
        check("t1_c3_pc", pc, 0);
        step();
        check("t1_c4_valid", act_valid, 0);
        check("t1_c4_pc", pc, 1);
        check("t1_c4_state", dbg_state, S_FETCH);
        step(); step();
        check("t1_c6_done", done, 1);
        check("t1_c6_busy", busy, 0);
        check("t1_c6_state", dbg_state, S_DONE);
        check("t1_c6_pc", pc, 1);
        check("t1_xfers", xfers - x0, 1);

        // back-pressure for 10 cycles
        act_ready = 1'b0;
        x0 = xfers;
        start = 1'b1; step(); start = 1'b0;
        check("t2_c1_done_cleared", done, 0);
        step(); step();
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", act_valid, 1);
            check("t2_hold_type", act_type, 2);
            check("t2_hold_data", act_data, 8'h5A);
            check("t2_hold_pc", pc, 0);
            step();
        end
        act_ready = 1'b1;
        check("t2_c13_valid", act_valid, 1);
        step();
        check("t2_c14_valid", act_valid, 0);
        check("t2_c14_pc", pc, 1);
        check("t2_xfers", xfers - x0, 1);
        step(); step();
        check("t2_done", done, 1);

        // timed wait of 3 units = 300 ticks
        rom[0] = 16'h0303; rom[1] = 16'h0007;
        tick_en = 1'b1;
        t0 = wt_ticks;
        found = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (dbg_state == S_FETCH && pc == 8'd1) found = 1'b1;
        end
        check("t3_exit_seen", found, 1);
        check("t3_tick_count", wt_ticks - t0, 300);
        check("t3_exit_latency", cyc - last_tick_cyc, 2);
        tick_en = 1'b0;
        step(); step();
        check("t3_done", done, 1);

        // zero-length wait
        rom[0] = 16'h0003;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check("t3z_c3_state", dbg_state, S_WAIT_T);
        step();
        check("t3z_c4_state", dbg_state, S_FETCH);
        check("t3z_c4_pc", pc, 1);
        step(); step();
        check("t3z_done", done, 1);

        // waituntil fb[4], then conditional jump on fb[3]
        rom[0] = 16'h004B; rom[1] = 16'h102A; rom[2] = 16'h0007; rom[16] = 16'h0007;
        feedback_sig = 8'h00;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check("t4_c3_state", dbg_state, S_WAIT_S);
        for (int i = 0; i < 20; i++) begin
            step();
            check("t4_hold_state", dbg_state, S_WAIT_S);
        end
        feedback_sig = 8'h18;
        step();
        check("t4_exit_state", dbg_state, S_FETCH);
        check("t4_exit_pc", pc, 1);
        step(); step();
        check("t4_jump_pc", pc, 8'h10);
        check("t4_jump_rom_addr", rom_addr, 8'h10);
        step(); step();
        check("t4_done", done, 1);
        check("t4_done_pc", pc, 8'h10);
        feedback_sig = 8'h10;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check("t4b_c3_state", dbg_state, S_WAIT_S);
        step();
        check("t4b_c4_pc", pc, 1);
        step(); step();
        check("t4b_nt_state", dbg_state, S_FETCH);
        check("t4b_nt_pc", pc, 2);
        step(); step();
        check("t4b_done", done, 1);
        feedback_sig = 8'h00;

        // stop mid-count, start while busy, stop over start
        rom[0] = 16'h0000; rom[1] = 16'h0303; rom[2] = 16'h0007;
        tick_en = 1'b1;
        t0 = wt_ticks;
        found = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            if (wt_ticks - t0 >= 150) found = 1'b1;
        end
        check("t5_mid_reached", found, 1);
        check("t5_mid_state", dbg_state, S_WAIT_T);
        check("t5_mid_pc", pc, 1);
        check("t5_mid_cnt", dbg_wait_cnt, 150);
        start = 1'b1; step(); start = 1'b0;
        check("t5_busy_start_state", dbg_state, S_WAIT_T);
        check("t5_busy_start_pc", pc, 1);
        stop = 1'b1; step(); stop = 1'b0;
        tick_en = 1'b0;
        check("t5_stop_state", dbg_state, S_IDLE);
        check("t5_stop_cnt", dbg_wait_cnt, 0);
        check("t5_stop_pc", pc, 1);
        check("t5_stop_rom_addr", rom_addr, 1);
        check("t5_stop_busy", busy, 0);
        check("t5_stop_done", done, 0);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("t5_prio_state", dbg_state, S_IDLE);
        check("t5_prio_pc", pc, 1);

        // asynchronous reset during a stalled action
        rom[0] = 16'h0000; rom[1] = 16'h5A11; rom[2] = 16'h0007;
        act_ready = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step(); step();
        check("t6_act_valid", act_valid, 1);
        check("t6_act_pc", pc, 1);
        #2; rst = 1'b1; #1;
        check("t6_rst_valid", act_valid, 0);
        check("t6_rst_state", dbg_state, S_IDLE);
        check("t6_rst_pc", pc, 0);
        check("t6_rst_rom_addr", rom_addr, 0);
        check("t6_rst_type", act_type, 0);
        check("t6_rst_data", act_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        #2; rst = 1'b0;
        act_ready = 1'b1;
        step();
        check("t6_post_state", dbg_state, S_IDLE);

        // 2-bit pc: illegal op, constant-0 select, truncated jump target
        rom_b[0] = 16'h0000; rom_b[1] = 16'h00AA; rom_b[2] = 16'h0702; rom_b[3] = 16'h0007;
        start_b = 1'b1; step(); start_b = 1'b0;
        check("t7_c1_state", dbg_state_b, S_FETCH);
        step(); step();
        check("t7_nop_pc", pc_b, 1);
        step(); step();
        check("t7_sel0_pc", pc_b, 2);
        step(); step();
        check("t7_trunc_pc", pc_b, 3);
        check("t7_trunc_rom_addr", rom_addr_b, 3);
        step(); step();
        check("t7_done", done_b, 1);

        // pc wrap 3 -> 0
        rom_b[0] = 16'hFF02; rom_b[3] = 16'h0004;
        start_b = 1'b1; step(); start_b = 1'b0;
        check("t7w_c1_pc", pc_b, 0);
        check("t7w_c1_done", done_b, 0);
        step(); step();
        check("t7w_jump_pc", pc_b, 3);
        step(); step();
        check("t7w_wrap_pc", pc_b, 0);
        check("t7w_wrap_state", dbg_state_b, S_FETCH);
        check("t7w_wrap_rom_addr", rom_addr_b, 0);
        stop_b = 1'b1; step(); stop_b = 1'b0;
        check("t7w_stop_state", dbg_state_b, S_IDLE);

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
